// File: rtl/arcade_input_mapper_if.sv
// Pad-side bus of the arcade input mapper: raw hps_io joystick words and mode
// controls in, conditioned per-player lines out.
interface arcade_input_mapper_if #(
  parameter int NPLAYERS = 2,
  parameter int NBTN     = 1
);
  logic [NPLAYERS*16-1:0]   joy_in;
  logic                     share_mode;
  logic                     socd_last;
  logic [NPLAYERS*NBTN-1:0] af_en;
  logic [NPLAYERS-1:0]      left;
  logic [NPLAYERS-1:0]      right;
  logic [NPLAYERS*NBTN-1:0] btn;
  logic [NPLAYERS-1:0]      start;
  logic                     coin;

  modport master (
    output joy_in, share_mode, socd_last, af_en,
    input  left, right, btn, start, coin
  );

  modport slave (
    input  joy_in, share_mode, socd_last, af_en,
    output left, right, btn, start, coin
  );
endinterface

// File: rtl/arcade_input_mapper.sv
// Conditions N joystick pads into per-player left/right/button/start lines with
// SOCD resolution, per-button autofire and a one-shot coin pulse with lockout.
module arcade_input_mapper #(
  parameter int NPLAYERS   = 2,
  parameter int NBTN       = 1,
  parameter int START_BIT  = 5,
  parameter int COIN_BIT   = 7,
  parameter int COIN_PULSE = 12000,
  parameter int COIN_GAP   = 24000,
  parameter int AF_HALF    = 600000
) (
  input  logic                  clk_sys,
  input  logic                  reset,
  arcade_input_mapper_if.slave  bus
);

  localparam int NB       = NPLAYERS * NBTN;
  localparam int AF_W     = $clog2(AF_HALF + 1);
  localparam int COIN_MAX = (COIN_PULSE > COIN_GAP) ? COIN_PULSE : COIN_GAP;
  localparam int CW       = $clog2(COIN_MAX + 1);
  localparam logic [AF_W-1:0] AF_LAST    = AF_W'(AF_HALF);
  localparam logic [CW-1:0]   PULSE_LAST = CW'(COIN_PULSE - 1);
  localparam logic [CW-1:0]   GAP_LAST   = CW'(COIN_GAP - 1);

  typedef enum logic [1:0] {WIN_NONE, WIN_LEFT, WIN_RIGHT} win_e;
  typedef enum logic [1:0] {C_IDLE, C_PULSE, C_GAP, C_WAIT_REL} coin_e;

  logic [15:0]         w_pad_or;
  logic [15:0]         w_src [NPLAYERS];
  logic [NPLAYERS-1:0] w_l, w_r, w_left_nxt, w_right_nxt, w_start_nxt;
  win_e                w_win_nxt [NPLAYERS];
  logic [NB-1:0]       w_held, w_btn_nxt;
  logic [AF_W-1:0]     w_af_cnt_nxt [NB];
  logic                w_coin_raw;
  coin_e               w_cstate_nxt;
  logic [CW-1:0]       w_ccnt_nxt;

  logic [NPLAYERS-1:0] r_left, r_right, r_start, r_prev_l, r_prev_r;
  win_e                r_win [NPLAYERS];
  logic [NB-1:0]       r_btn;
  logic [AF_W-1:0]     r_af_cnt [NB];
  coin_e               r_cstate;
  logic [CW-1:0]       r_ccnt;
  logic                r_coin, r_coin_prev, r_post_rst;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_pad_or = '0;
    for (int p = 0; p < NPLAYERS; p++) w_pad_or = w_pad_or | bus.joy_in[16*p +: 16];
    w_coin_raw = w_pad_or[COIN_BIT];
    for (int p = 0; p < NPLAYERS; p++) begin
      w_src[p]       = bus.share_mode ? w_pad_or : bus.joy_in[16*p +: 16];
      w_start_nxt[p] = bus.share_mode ? w_pad_or[START_BIT + p] : w_src[p][START_BIT];
      w_l[p]         = w_src[p][1];
      w_r[p]         = w_src[p][0];
      w_win_nxt[p]   = WIN_NONE;
      w_left_nxt[p]  = w_l[p] & ~w_r[p];
      w_right_nxt[p] = w_r[p] & ~w_l[p];
      // Last-wins: a fresh press against a held opposite takes over; a tie stays neutral.
      if (w_l[p] && w_r[p] && bus.socd_last) begin
        if (!r_prev_l[p] && !r_prev_r[p]) w_win_nxt[p] = WIN_NONE;
        else if (!r_prev_l[p])            w_win_nxt[p] = WIN_LEFT;
        else if (!r_prev_r[p])            w_win_nxt[p] = WIN_RIGHT;
        else                              w_win_nxt[p] = r_win[p];
        w_left_nxt[p]  = (w_win_nxt[p] == WIN_LEFT);
        w_right_nxt[p] = (w_win_nxt[p] == WIN_RIGHT);
      end
    end
  end

  // Autofire phase counter counts 1..AF_HALF; zero means idle, so the next
  // active cycle always begins a fresh high phase.
  always_comb begin
    for (int p = 0; p < NPLAYERS; p++) begin
      for (int b = 0; b < NBTN; b++) begin
        w_held[p*NBTN + b] = w_src[p][4 + b];
      end
    end
    for (int i = 0; i < NB; i++) begin
      w_btn_nxt[i]    = w_held[i];
      w_af_cnt_nxt[i] = '0;
      if (w_held[i] && bus.af_en[i]) begin
        if (r_af_cnt[i] == '0) begin
          w_btn_nxt[i]    = 1'b1;
          w_af_cnt_nxt[i] = AF_W'(1);
        end else if (r_af_cnt[i] == AF_LAST) begin
          w_btn_nxt[i]    = ~r_btn[i];
          w_af_cnt_nxt[i] = AF_W'(1);
        end else begin
          w_btn_nxt[i]    = r_btn[i];
          w_af_cnt_nxt[i] = r_af_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_cstate_nxt = r_cstate;
    w_ccnt_nxt   = r_ccnt;
    case (r_cstate)
      C_IDLE: begin
        // A coin still held across reset must not count as a fresh insertion.
        if (r_post_rst && w_coin_raw) begin
          w_cstate_nxt = C_WAIT_REL;
        end else if (w_coin_raw && !r_coin_prev) begin
          w_cstate_nxt = C_PULSE;
          w_ccnt_nxt   = '0;
        end
      end
      C_PULSE: begin
        if (r_ccnt == PULSE_LAST) begin
          w_cstate_nxt = C_GAP;
          w_ccnt_nxt   = '0;
        end else begin
          w_ccnt_nxt = r_ccnt + 1'b1;
        end
      end
      C_GAP: begin
        if (r_ccnt == GAP_LAST) begin
          w_cstate_nxt = w_coin_raw ? C_WAIT_REL : C_IDLE;
          w_ccnt_nxt   = '0;
        end else begin
          w_ccnt_nxt = r_ccnt + 1'b1;
        end
      end
      C_WAIT_REL: if (!w_coin_raw) w_cstate_nxt = C_IDLE;
      default:    w_cstate_nxt = C_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_left      <= '0;
      r_right     <= '0;
      r_start     <= '0;
      r_prev_l    <= '0;
      r_prev_r    <= '0;
      r_btn       <= '0;
      r_cstate    <= C_IDLE;
      r_ccnt      <= '0;
      r_coin      <= 1'b0;
      r_coin_prev <= 1'b0;
      r_post_rst  <= 1'b1;
      for (int p = 0; p < NPLAYERS; p++) r_win[p] <= WIN_NONE;
      for (int i = 0; i < NB; i++) r_af_cnt[i] <= '0;
    end else begin
      r_left      <= w_left_nxt;
      r_right     <= w_right_nxt;
      r_start     <= w_start_nxt;
      r_prev_l    <= w_l;
      r_prev_r    <= w_r;
      r_btn       <= w_btn_nxt;
      r_cstate    <= w_cstate_nxt;
      r_ccnt      <= w_ccnt_nxt;
      r_coin      <= (w_cstate_nxt == C_PULSE);
      r_coin_prev <= w_coin_raw;
      r_post_rst  <= 1'b0;
      for (int p = 0; p < NPLAYERS; p++) r_win[p] <= w_win_nxt[p];
      for (int i = 0; i < NB; i++) r_af_cnt[i] <= w_af_cnt_nxt[i];
    end
  end

  assign bus.left  = r_left;
  assign bus.right = r_right;
  assign bus.btn   = r_btn;
  assign bus.start = r_start;
  assign bus.coin  = r_coin;

endmodule

// File: tb/tb_arcade_input_mapper.sv
// Directed bench for arcade_input_mapper: two players, one button, short coin
// and autofire timings so every phase boundary is reachable in a few cycles.
module tb_arcade_input_mapper;

  logic clk_sys;
  logic reset;
  int   checks;
  int   errors;

  arcade_input_mapper_if #(.NPLAYERS(2), .NBTN(1)) bus ();

  arcade_input_mapper #(
    .NPLAYERS(2), .NBTN(1), .START_BIT(5), .COIN_BIT(7),
    .COIN_PULSE(4), .COIN_GAP(6), .AF_HALF(3)
  ) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .bus     (bus)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  // Inputs change just after a falling edge; outputs are read on a later falling edge.
  task automatic step(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic set_pads(input logic [15:0] p1, input logic [15:0] p0);
    bus.joy_in = {p1, p0};
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.share_mode = 1'b0;
    bus.socd_last  = 1'b0;
    bus.af_en      = 2'b00;
    set_pads(16'hFFFF, 16'hFFFF);
    step(3);
    checks++;
    if ({bus.left, bus.right, bus.btn, bus.start, bus.coin} !== 9'b0) begin
      errors++;
      $display("FAIL reset_outputs got %b exp 0", {bus.left, bus.right, bus.btn, bus.start, bus.coin});
    end
    reset = 1'b0;
    step(1);
    checks++;
    if (bus.left !== 2'b00 || bus.right !== 2'b00) begin
      errors++;
      $display("FAIL reset_release_lr got l=%b r=%b exp 00 00", bus.left, bus.right);
    end
    checks++;
    if (bus.btn !== 2'b11 || bus.start !== 2'b11) begin
      errors++;
      $display("FAIL reset_release_btn got btn=%b start=%b exp 11 11", bus.btn, bus.start);
    end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (bus.coin !== 1'b0) begin
        errors++;
        $display("FAIL reset_held_coin cycle %0d got %b exp 0", i, bus.coin);
      end
      step(1);
    end
    set_pads(16'hFF7F, 16'hFF7F);
    step(2);
    checks++;
    if (bus.coin !== 1'b0) begin
      errors++;
      $display("FAIL reset_coin_release got %b exp 0", bus.coin);
    end
    set_pads(16'h0000, 16'h0080);
    step(1);
    checks++;
    if (bus.coin !== 1'b1) begin
      errors++;
      $display("FAIL reset_coin_repress got %b exp 1", bus.coin);
    end
    set_pads(16'h0000, 16'h0000);
    step(12);
  endtask

  task automatic test_per_pad();
    bus.share_mode = 1'b0;
    bus.socd_last  = 1'b0;
    set_pads(16'h0001, 16'h0002);
    step(1);
    checks++;
    if (bus.left !== 2'b01 || bus.right !== 2'b10) begin
      errors++;
      $display("FAIL per_pad got l=%b r=%b exp 01 10", bus.left, bus.right);
    end
    bus.share_mode = 1'b1;
    step(1);
    checks++;
    if (bus.left !== 2'b00 || bus.right !== 2'b00) begin
      errors++;
      $display("FAIL shared_neutral got l=%b r=%b exp 00 00", bus.left, bus.right);
    end
    bus.share_mode = 1'b0;
    set_pads(16'h0000, 16'h0000);
    step(2);
  endtask

  task automatic test_socd_last();
    bus.socd_last = 1'b1;
    set_pads(16'h0000, 16'h0001);
    step(1);
    checks++;
    if (bus.left[0] !== 1'b0 || bus.right[0] !== 1'b1) begin
      errors++;
      $display("FAIL socd_right got l=%b r=%b exp 0 1", bus.left[0], bus.right[0]);
    end
    step(5);
    set_pads(16'h0000, 16'h0003);
    step(1);
    checks++;
    if (bus.left[0] !== 1'b1 || bus.right[0] !== 1'b0) begin
      errors++;
      $display("FAIL socd_left_wins got l=%b r=%b exp 1 0", bus.left[0], bus.right[0]);
    end
    step(3);
    checks++;
    if (bus.left[0] !== 1'b1 || bus.right[0] !== 1'b0) begin
      errors++;
      $display("FAIL socd_left_holds got l=%b r=%b exp 1 0", bus.left[0], bus.right[0]);
    end
    set_pads(16'h0000, 16'h0001);
    step(1);
    checks++;
    if (bus.left[0] !== 1'b0 || bus.right[0] !== 1'b1) begin
      errors++;
      $display("FAIL socd_handover got l=%b r=%b exp 0 1", bus.left[0], bus.right[0]);
    end
    set_pads(16'h0000, 16'h0000);
    step(1);
    set_pads(16'h0000, 16'h0003);
    step(1);
    checks++;
    if (bus.left[0] !== 1'b0 || bus.right[0] !== 1'b0) begin
      errors++;
      $display("FAIL socd_tie got l=%b r=%b exp 0 0", bus.left[0], bus.right[0]);
    end
    step(3);
    checks++;
    if (bus.left[0] !== 1'b0 || bus.right[0] !== 1'b0) begin
      errors++;
      $display("FAIL socd_tie_holds got l=%b r=%b exp 0 0", bus.left[0], bus.right[0]);
    end
    set_pads(16'h0000, 16'h0002);
    step(1);
    checks++;
    if (bus.left[0] !== 1'b1 || bus.right[0] !== 1'b0) begin
      errors++;
      $display("FAIL socd_tie_release got l=%b r=%b exp 1 0", bus.left[0], bus.right[0]);
    end
    bus.socd_last = 1'b0;
    set_pads(16'h0000, 16'h0000);
    step(2);
  endtask

  task automatic test_coin();
    int highs;
    set_pads(16'h0000, 16'h0080);
    step(1);
    set_pads(16'h0000, 16'h0000);
    for (int i = 1; i <= 6; i++) begin
      checks++;
      if (bus.coin !== (i <= 4)) begin
        errors++;
        $display("FAIL coin_pulse cycle %0d got %b exp %b", i, bus.coin, (i <= 4));
      end
      step(1);
    end
    set_pads(16'h0080, 16'h0000);
    step(1);
    set_pads(16'h0000, 16'h0000);
    highs = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.coin === 1'b1) highs++;
      step(1);
    end
    checks++;
    if (highs != 0) begin
      errors++;
      $display("FAIL coin_gap_repress got %0d high cycles exp 0", highs);
    end
    set_pads(16'h0000, 16'h0080);
    highs = 0;
    for (int i = 0; i < 50; i++) begin
      step(1);
      if (bus.coin === 1'b1) highs++;
    end
    checks++;
    if (highs != 4) begin
      errors++;
      $display("FAIL coin_hold got %0d high cycles exp 4", highs);
    end
    set_pads(16'h0000, 16'h0000);
    step(2);
    set_pads(16'h0000, 16'h0080);
    step(2);
    checks++;
    if (bus.coin !== 1'b1) begin
      errors++;
      $display("FAIL coin_before_reset got %b exp 1", bus.coin);
    end
    reset = 1'b1;
    step(1);
    checks++;
    if (bus.coin !== 1'b0) begin
      errors++;
      $display("FAIL coin_mid_reset got %b exp 0", bus.coin);
    end
    reset = 1'b0;
    highs = 0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (bus.coin === 1'b1) highs++;
    end
    checks++;
    if (highs != 0) begin
      errors++;
      $display("FAIL coin_held_after_reset got %0d high cycles exp 0", highs);
    end
    set_pads(16'h0000, 16'h0000);
    step(2);
    set_pads(16'h0080, 16'h0000);
    step(1);
    checks++;
    if (bus.coin !== 1'b1) begin
      errors++;
      $display("FAIL coin_after_reset_press got %b exp 1", bus.coin);
    end
    set_pads(16'h0000, 16'h0000);
    step(12);
  endtask

  task automatic test_autofire();
    logic exp_b;
    bus.af_en = 2'b01;
    set_pads(16'h0010, 16'h0010);
    for (int i = 0; i < 20; i++) begin
      step(1);
      exp_b = ((i / 3) % 2) == 0;
      checks++;
      if (bus.btn[0] !== exp_b || bus.btn[1] !== 1'b1) begin
        errors++;
        $display("FAIL af_pattern cycle %0d got %b exp %b1", i, bus.btn, exp_b);
      end
    end
    set_pads(16'h0000, 16'h0000);
    step(1);
    checks++;
    if (bus.btn !== 2'b00) begin
      errors++;
      $display("FAIL af_release got %b exp 00", bus.btn);
    end
    set_pads(16'h0000, 16'h0010);
    step(1);
    checks++;
    if (bus.btn[0] !== 1'b1) begin
      errors++;
      $display("FAIL af_repress got %b exp 1", bus.btn[0]);
    end
    step(3);
    checks++;
    if (bus.btn[0] !== 1'b0) begin
      errors++;
      $display("FAIL af_repress_low got %b exp 0", bus.btn[0]);
    end
    bus.af_en = 2'b00;
    step(1);
    checks++;
    if (bus.btn[0] !== 1'b1) begin
      errors++;
      $display("FAIL af_disabled got %b exp 1", bus.btn[0]);
    end
    bus.af_en = 2'b01;
    for (int i = 0; i < 4; i++) begin
      step(1);
      checks++;
      if (bus.btn[0] !== (i < 3)) begin
        errors++;
        $display("FAIL af_restart cycle %0d got %b exp %b", i, bus.btn[0], (i < 3));
      end
    end
    bus.af_en = 2'b00;
    set_pads(16'h0000, 16'h0000);
    step(2);
  endtask

  task automatic test_shared_start();
    bus.share_mode = 1'b1;
    set_pads(16'h0040, 16'h0000);
    step(1);
    checks++;
    if (bus.start !== 2'b10) begin
      errors++;
      $display("FAIL shared_start_p1 got %b exp 10", bus.start);
    end
    set_pads(16'h0000, 16'h0020);
    step(1);
    checks++;
    if (bus.start !== 2'b01) begin
      errors++;
      $display("FAIL shared_start_p0 got %b exp 01", bus.start);
    end
    bus.share_mode = 1'b0;
    set_pads(16'h0020, 16'h0040);
    step(1);
    checks++;
    if (bus.start !== 2'b10) begin
      errors++;
      $display("FAIL per_pad_start got %b exp 10", bus.start);
    end
    set_pads(16'h0000, 16'h0000);
    step(1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus.joy_in     = '0;
    bus.share_mode = 1'b0;
    bus.socd_last  = 1'b0;
    bus.af_en      = '0;
    test_reset();
    test_per_pad();
    test_socd_last();
    test_coin();
    test_autofire();
    test_shared_start();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
